// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon Says round controller.
// Builds an LFSR-driven arrow sequence, plays it back on show_dir, then checks
// the player's presses against it. Each completed round grows the sequence by one.
// Optional feature macro: SIMON_TIMEOUT_EN (WAIT_IN gives up after TIMEOUT_CYCLES -> LOSE).
module simon_sequencer #(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned SHOW_CYCLES    = 25000000,
    parameter int unsigned GAP_CYCLES     = 12500000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] direction_in,
    output logic [2:0] show_dir,
    output logic [4:0] round,
    output logic       playing,
    output logic       awaiting_input,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
    } state_t;

    localparam logic [31:0] LP_SHOW_LAST = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] LP_GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [4:0]  LP_MAX_LEN   = 5'(MAX_LEN);
    localparam logic [15:0] LP_SEED      = 16'hACE1;
`ifdef SIMON_TIMEOUT_EN
    localparam logic [31:0] LP_TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [31:0] LP_TIMEOUT_UNUSED = 32'(TIMEOUT_CYCLES);
`endif

    // Fibonacci LFSR step, taps 16/14/13/11, shifting left.
    function automatic logic [15:0] f_lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_mem [MAX_LEN];
    logic [4:0]  r_len, w_len_nxt;
    logic [4:0]  r_idx, w_idx_nxt;
    logic [31:0] r_phase, w_phase_nxt;
    logic [15:0] r_lfsr;
    logic        r_prev_none;
    logic        w_wr_en;
    logic        w_press;
    logic [4:0]  w_last_idx;
    logic [1:0]  w_rd_cur, w_rd_nxt;
    logic [2:0]  w_show_nxt;
    logic [2:0]  r_show_dir;
    logic        r_playing, r_awaiting, r_win, r_lose;
`ifdef SIMON_TIMEOUT_EN
    logic [31:0] r_tmo, w_tmo_nxt;
`endif

    // A press is a non-none code following a none cycle, so a held key counts once.
    assign w_press    = ~direction_in[2] & r_prev_none;
    assign w_last_idx = r_len - 5'd1;

    // Read the stored arrow at the current index for press comparison.
    always_comb begin
        w_rd_cur = 2'b00;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            w_rd_cur = (5'(i) == r_idx) ? r_mem[i] : w_rd_cur;
        end
    end

    // Next-state and counter update logic for the round FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_phase_nxt = r_phase;
        w_wr_en     = 1'b0;
`ifdef SIMON_TIMEOUT_EN
        w_tmo_nxt   = r_tmo;
`endif
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) w_state_nxt = S_CLEAR;
                else       w_state_nxt = r_state;
            end
            S_CLEAR: begin
                w_len_nxt   = 5'd0;
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                w_wr_en     = 1'b1;
                w_len_nxt   = r_len + 5'd1;
                w_idx_nxt   = 5'd0;
                w_phase_nxt = 32'd0;
                w_state_nxt = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (r_phase == LP_SHOW_LAST) begin
                    w_phase_nxt = 32'd0;
                    w_state_nxt = S_SHOW_OFF;
                end else begin
                    w_phase_nxt = r_phase + 32'd1;
                end
            end
            S_SHOW_OFF: begin
                if (r_phase == LP_GAP_LAST) begin
                    w_phase_nxt = 32'd0;
                    if (r_idx == w_last_idx) begin
                        w_idx_nxt   = 5'd0;
                        w_state_nxt = S_WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
                        w_tmo_nxt   = 32'd0;
`endif
                    end else begin
                        w_idx_nxt   = r_idx + 5'd1;
                        w_state_nxt = S_SHOW_ON;
                    end
                end else begin
                    w_phase_nxt = r_phase + 32'd1;
                end
            end
            S_WAIT_IN: begin
                if (w_press) begin
`ifdef SIMON_TIMEOUT_EN
                    w_tmo_nxt = 32'd0;
`endif
                    if (direction_in[1:0] != w_rd_cur) begin
                        w_state_nxt = S_LOSE;
                    end else if (r_idx == w_last_idx) begin
                        if (r_len == LP_MAX_LEN) w_state_nxt = S_WIN;
                        else                     w_state_nxt = S_ADD;
                    end else begin
                        w_idx_nxt = r_idx + 5'd1;
                    end
                end else begin
`ifdef SIMON_TIMEOUT_EN
                    // A press in the expiry cycle takes the branch above instead.
                    if (r_tmo == LP_TMO_LAST) w_state_nxt = S_LOSE;
                    else                      w_tmo_nxt   = r_tmo + 32'd1;
`else
                    w_state_nxt = S_WAIT_IN;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Decode next-cycle outputs so the registered outputs line up with the state.
    always_comb begin
        w_rd_nxt   = 2'b00;
        w_show_nxt = 3'b111;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            w_rd_nxt = (5'(i) == w_idx_nxt) ? r_mem[i] : w_rd_nxt;
        end
        if (w_state_nxt == S_SHOW_ON) begin
            // Leaving ADD with len==0 shows the arrow being written this very cycle.
            if (w_wr_en && (w_idx_nxt == r_len)) w_show_nxt = {1'b0, r_lfsr[1:0]};
            else                                 w_show_nxt = {1'b0, w_rd_nxt};
        end else begin
            w_show_nxt = 3'b111;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Sequence storage: the ADD cycle captures the LFSR's low bit pair at index len.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(MAX_LEN); i++) r_mem[i] <= 2'b00;
        end else begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                if (w_wr_en && (5'(i) == r_len)) r_mem[i] <= r_lfsr[1:0];
            end
        end
    end

    // Counters, LFSR, press history and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_len       <= 5'd0;
            r_idx       <= 5'd0;
            r_phase     <= 32'd0;
            r_lfsr      <= LP_SEED;
            r_prev_none <= 1'b1;
            r_show_dir  <= 3'b111;
            r_playing   <= 1'b0;
            r_awaiting  <= 1'b0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
            r_tmo       <= 32'd0;
`endif
        end else begin
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_phase     <= w_phase_nxt;
            r_lfsr      <= f_lfsr_next(r_lfsr);
            r_prev_none <= direction_in[2];
            r_show_dir  <= w_show_nxt;
            r_playing   <= (w_state_nxt == S_SHOW_ON) || (w_state_nxt == S_SHOW_OFF);
            r_awaiting  <= (w_state_nxt == S_WAIT_IN);
            r_win       <= (w_state_nxt == S_WIN);
            r_lose      <= (w_state_nxt == S_LOSE);
`ifdef SIMON_TIMEOUT_EN
            r_tmo       <= w_tmo_nxt;
`endif
        end
    end

    assign show_dir       = r_show_dir;
    assign round          = r_len;
    assign playing        = r_playing;
    assign awaiting_input = r_awaiting;
    assign win            = r_win;
    assign lose           = r_lose;

endmodule

// File: tb/tb_simon_sequencer.sv
// Testbench for simon_sequencer: scenario tasks checked against a queue-based
// model of the game sequence and an independent LFSR model.
module tb_simon_sequencer;

    localparam int MAX_LEN = 3;
    localparam int SHOW    = 4;
    localparam int GAP     = 2;
    localparam int TMO     = 20;

    logic       clock        = 1'b0;
    logic       resetn       = 1'b0;
    logic       start        = 1'b0;
    logic [2:0] direction_in = 3'b111;
    logic [2:0] show_dir;
    logic [4:0] round;
    logic       playing, awaiting_input, win, lose;

    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          hold_left = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  seq [$];

    simon_sequencer #(
        .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .direction_in(direction_in),
        .show_dir(show_dir), .round(round), .playing(playing),
        .awaiting_input(awaiting_input), .win(win), .lose(lose)
    );

    always #5 clock = ~clock;

    // Reference LFSR: feedback is the parity of the tap mask 0xB400.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_lfsr <= 16'hACE1;
        else         m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    function automatic logic [11:0] outs();
        return {show_dir, round, playing, awaiting_input, win, lose};
    endfunction

    // flags = {playing, awaiting_input, win, lose}
    function automatic logic [11:0] vec(input logic [2:0] s, input int r, input logic [3:0] f);
        return {s, 5'(r), f};
    endfunction

    task automatic step();
        @(negedge clock);
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) direction_in = 3'b111;
        end
    endtask

    // Called in the ADD cycle: captures the new arrow and checks the whole playback.
    task automatic play_round(input string tag);
        logic [11:0] exp;
        seq.push_back(m_lfsr[1:0]);
        exp = vec(3'b111, seq.size() - 1, 4'b0000);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL %s_add: got %h want %h", tag, outs(), exp); end
        for (int i = 0; i < seq.size(); i++) begin
            for (int c = 0; c < SHOW; c++) begin
                step();
                exp = vec({1'b0, seq[i]}, seq.size(), 4'b1000);
                n_cmp++;
                if (outs() !== exp) begin n_bad++; $display("FAIL %s_show%0d: got %h want %h", tag, i, outs(), exp); end
            end
            for (int c = 0; c < GAP; c++) begin
                step();
                exp = vec(3'b111, seq.size(), 4'b1000);
                n_cmp++;
                if (outs() !== exp) begin n_bad++; $display("FAIL %s_gap%0d: got %h want %h", tag, i, outs(), exp); end
            end
        end
        step();
        exp = vec(3'b111, seq.size(), 4'b0100);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL %s_await: got %h want %h", tag, outs(), exp); end
    endtask

    task automatic start_game(input string tag);
        logic [11:0] exp;
        start = 1'b1;
        step();
        start = 1'b0;
        exp = vec(3'b111, seq.size(), 4'b0000);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL %s_clear: got %h want %h", tag, outs(), exp); end
        step();
        seq.delete();
        play_round(tag);
    endtask

    task automatic press_mid(input int i, input string tag);
        logic [11:0] exp;
        direction_in = {1'b0, seq[i]};
        hold_left = 1;
        step();
        exp = vec(3'b111, seq.size(), 4'b0100);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL %s_mid%0d: got %h want %h", tag, i, outs(), exp); end
        step();
    endtask

    task automatic press_last(input int hold, input string tag);
        direction_in = {1'b0, seq[seq.size() - 1]};
        hold_left = hold;
        step();
        play_round(tag);
    endtask

    task automatic wait_random(input string tag);
        logic [11:0] exp;
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
            step();
            exp = vec(3'b111, seq.size(), 4'b0100);
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL %s_wait: got %h want %h", tag, outs(), exp); end
        end
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        exp = vec(3'b111, 0, 4'b0000);
        repeat (3) @(negedge clock);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL reset_hold: got %h want %h", outs(), exp); end
        resetn = 1'b1;
        for (int k = 0; k < 10; k++) step();
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL reset_idle: got %h want %h", outs(), exp); end
        repeat ($urandom_range(0, 5)) step();
    endtask

    task automatic test_first_round();
        start_game("round1");
        wait_random("r1");
        press_last(3, "round2");
    endtask

    task automatic test_held_key();
        logic [11:0] exp;
        exp = vec(3'b111, 2, 4'b0100);
        direction_in = {1'b0, seq[0]};
        hold_left = 5;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL held_key%0d: got %h want %h", k, outs(), exp); end
        end
    endtask

    task automatic test_wrong_code();
        logic [11:0] exp;
        exp = vec(3'b111, 2, 4'b0001);
        direction_in = {1'b0, seq[1] ^ 2'b01};
        hold_left = 1;
        step();
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL wrong_lose: got %h want %h", outs(), exp); end
        for (int k = 0; k < 4; k++) begin
            direction_in = 3'($urandom_range(0, 7));
            step();
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL lose_sticky%0d: got %h want %h", k, outs(), exp); end
        end
        direction_in = 3'b111;
        step();
    endtask

    task automatic test_restart();
        start_game("restart");
    endtask

    task automatic test_win();
        logic [11:0] exp;
        wait_random("w1");
        start = 1'b1;
        press_last(3, "win_r2");
        start = 1'b0;
        wait_random("w2");
        press_mid(0, "win_r2");
        press_last(2, "win_r3");
        press_mid(0, "win_r3");
        press_mid(1, "win_r3");
        direction_in = {1'b0, seq[2]};
        hold_left = 1;
        step();
        exp = vec(3'b111, 3, 4'b0010);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL win: got %h want %h", outs(), exp); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL win_sticky%0d: got %h want %h", k, outs(), exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp;
        start_game("rm_r1");
        direction_in = {1'b0, seq[0]};
        hold_left = 1;
        step();
        seq.push_back(m_lfsr[1:0]);
        for (int k = 0; k < 3; k++) step();
        exp = vec({1'b0, seq[0]}, 2, 4'b1000);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL rm_show: got %h want %h", outs(), exp); end
        resetn = 1'b0;
        #1;
        exp = vec(3'b111, 0, 4'b0000);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL rm_async: got %h want %h", outs(), exp); end
        step();
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL rm_reset: got %h want %h", outs(), exp); end
        resetn = 1'b1;
        seq.delete();
        hold_left = 0;
        direction_in = 3'b111;
        repeat ($urandom_range(1, 4)) step();
        start_game("after_reset");
    endtask

`ifdef SIMON_TIMEOUT_EN
    task automatic test_timeout();
        logic [11:0] exp;
        for (int c = 1; c < TMO; c++) begin
            step();
            exp = vec(3'b111, 1, 4'b0100);
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL tmo_wait%0d: got %h want %h", c, outs(), exp); end
        end
        press_last(1, "tmo_press19");
        for (int c = 0; c < 5; c++) step();
        press_mid(0, "tmo_mid");
        exp = vec(3'b111, 2, 4'b0100);
        for (int c = 2; c < TMO; c++) begin
            step();
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL tmo_restart%0d: got %h want %h", c, outs(), exp); end
        end
        step();
        exp = vec(3'b111, 2, 4'b0001);
        n_cmp++;
        if (outs() !== exp) begin n_bad++; $display("FAIL tmo_lose: got %h want %h", outs(), exp); end
    endtask
`else
    task automatic test_no_timeout();
        logic [11:0] exp;
        exp = vec(3'b111, 1, 4'b0100);
        for (int c = 0; c < 40; c++) begin
            step();
            n_cmp++;
            if (outs() !== exp) begin n_bad++; $display("FAIL no_timeout%0d: got %h want %h", c, outs(), exp); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_round();
        test_held_key();
        test_wrong_code();
        test_restart();
        test_win();
        test_reset_mid();
`ifdef SIMON_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
